// File: rtl/fetch_pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pc_sequencer_pkg
//
// Shared definitions for the instruction-fetch sequencer and its helpers.
//
// Contents:
//   INSTR_W        width of an instruction word and of every address
//   JIDX_W         width of the j/jal instruction-index field
//   NOP            instruction word used to clear the decode buffer
//   fetch_state_e  sequencer states (IDLE / FETCH / HOLD)
//   redirect_src_e which redirect source won arbitration in a cycle
//   word_align     force bits [1:0] of an address to zero
//   is_misaligned  true when bits [1:0] of an address are non-zero
// ----------------------------------------------------------------------------
package fetch_pc_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam int JIDX_W  = 26;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JR     = 2'd2,
        REDIR_JUMP   = 2'd3
    } redirect_src_e;

    // Instruction memory is word addressed in practice, so every PC the
    // sequencer produces has its two low bits cleared.
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

    // A redirect target with non-zero low bits is still followed (after
    // alignment) but is reported so software can trap on it.
    function automatic logic is_misaligned(input logic [INSTR_W-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/fetch_pc_sequencer_jump_target_gen.sv
// ----------------------------------------------------------------------------
// jump_target_gen
//
// Combinational j/jal target formation. The target keeps the top nibble of
// the jump's own pc_plus_4 and replaces the rest with the instruction index
// shifted left by two. Kept as its own module because the decode-side link
// logic builds the same address.
//
// Ports:
//   pc_plus_4_i  in  32  pc_plus_4 of the jump instruction
//   index_i      in  26  instruction-index field of the jump
//   target_o     out 32  {pc_plus_4_i[31:28], index_i, 2'b00}
// ----------------------------------------------------------------------------
module jump_target_gen
    import fetch_pc_sequencer_pkg::*;
(
    input  logic [INSTR_W-1:0] pc_plus_4_i,
    input  logic [JIDX_W-1:0]  index_i,
    output logic [INSTR_W-1:0] target_o
);

    // Only the region nibble of pc_plus_4 matters; the low bits are
    // reduced into a deliberately unused net so the full word can still be
    // passed in without width juggling at every call site.
    logic unused_pc_low_bits;
    assign unused_pc_low_bits = ^pc_plus_4_i[INSTR_W-5:0];

    // The jump region is the 256 MB segment of the instruction after the
    // jump, hence pc_plus_4 rather than the jump's own PC.
    always_comb begin
        target_o = {pc_plus_4_i[INSTR_W-1:INSTR_W-4], index_i, 2'b00};
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_pc_sequencer
//
// Instruction-fetch sequencer for the MIPS core. Owns the program counter,
// drives the instruction-memory request/ready handshake, holds one fetched
// instruction for decode, and redirects the PC on taken branches, jr and
// j/jal.
//
// Parameters:
//   RESET_PC          PC loaded on reset (word aligned)
//
// Ports:
//   clk               in   1   clock, all state changes on the rising edge
//   reset             in   1   synchronous active-high reset
//   imem_req          out  1   fetch request
//   imem_addr         out  32  fetch address (always the current PC)
//   imem_ready        in   1   imem_rdata valid this cycle (only with imem_req)
//   imem_rdata        in   32  fetched instruction word
//   if_valid          out  1   decode buffer holds an instruction
//   if_instr          out  32  buffered instruction
//   if_pc_plus_4      out  32  address of the buffered instruction + 4
//   id_ready          in   1   decode takes the buffer this cycle
//   ex_branch_taken   in   1   taken branch resolved in EX
//   ex_branch_target  in   32  branch target
//   id_jr             in   1   jr decoded
//   id_jr_target      in   32  register value for jr
//   id_jump           in   1   j/jal decoded
//   id_jump_index     in   26  instruction-index field
//   id_pc_plus_4      in   32  pc_plus_4 of the jump instruction
//   addr_err          out  1   one-cycle pulse: redirect target misaligned
// ----------------------------------------------------------------------------
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                clk,
    input  logic                reset,

    output logic                imem_req,
    output logic [INSTR_W-1:0]  imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,

    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [INSTR_W-1:0]  if_pc_plus_4,
    input  logic                id_ready,

    input  logic                ex_branch_taken,
    input  logic [INSTR_W-1:0]  ex_branch_target,
    input  logic                id_jr,
    input  logic [INSTR_W-1:0]  id_jr_target,
    input  logic                id_jump,
    input  logic [JIDX_W-1:0]   id_jump_index,
    input  logic [INSTR_W-1:0]  id_pc_plus_4,

    output logic                addr_err
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_FETCH = ST_FETCH;
    localparam logic [1:0] S_HOLD  = ST_HOLD;

    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] ppc4_q, ppc4_d;
    logic               addr_err_q, addr_err_d;

    logic [INSTR_W-1:0] jump_target;
    logic [INSTR_W-1:0] pc_plus_4;
    logic [1:0]         redirect_src;
    logic               redirect_valid;
    logic [INSTR_W-1:0] redirect_target;
    logic               fetch_accept;

    jump_target_gen u_jump_target_gen (
        .pc_plus_4_i (id_pc_plus_4),
        .index_i     (id_jump_index),
        .target_o    (jump_target)
    );

    assign pc_plus_4 = pc_q + 32'd4;

    // Redirect arbitration. EX holds the older instruction, so a taken
    // branch beats anything decode reports; between the two decode-side
    // sources jr wins over j/jal. The winning source also selects the raw
    // (possibly misaligned) target, which is checked and aligned later.
    always_comb begin
        redirect_src    = REDIR_NONE;
        redirect_target = RESET_PC;
        if (ex_branch_taken) begin
            redirect_src    = REDIR_BRANCH;
            redirect_target = ex_branch_target;
        end else if (id_jr) begin
            redirect_src    = REDIR_JR;
            redirect_target = id_jr_target;
        end else if (id_jump) begin
            redirect_src    = REDIR_JUMP;
            redirect_target = jump_target;
        end
        redirect_valid = (redirect_src != REDIR_NONE);
    end

    // The request is only offered in FETCH and only when a returning word
    // has somewhere to go: either the buffer is empty or decode is taking
    // it in the same cycle. This keeps an unconsumed instruction from ever
    // being overwritten, at the cost of a combinational path from id_ready.
    always_comb begin
        imem_req     = (state_q == S_FETCH) && (!valid_q || id_ready);
        fetch_accept = imem_req && imem_ready;
    end

    // Next-state logic. A redirect outside IDLE overrides everything else:
    // the PC jumps to the aligned target, the buffer is flushed even if
    // decode is asserting id_ready (that instruction is on the wrong path),
    // and any word returning this cycle is dropped. Without a redirect,
    // FETCH either refills the buffer, parks in HOLD because decode is
    // stalled, or just lets decode drain the buffer; HOLD waits for decode.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ppc4_d     = ppc4_q;
        addr_err_d = 1'b0;

        if ((state_q == S_FETCH || state_q == S_HOLD) && redirect_valid) begin
            state_d    = S_FETCH;
            pc_d       = word_align(redirect_target);
            valid_d    = 1'b0;
            addr_err_d = is_misaligned(redirect_target);
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (valid_q && !id_ready) begin
                        state_d = S_HOLD;
                    end else if (fetch_accept) begin
                        instr_d = imem_rdata;
                        ppc4_d  = pc_plus_4;
                        pc_d    = pc_plus_4;
                        valid_d = 1'b1;
                        state_d = id_ready ? S_FETCH : S_HOLD;
                    end else if (valid_q && id_ready) begin
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers. Reset is synchronous and wins over everything,
    // including any redirect or memory response presented during reset,
    // so an outstanding request is simply abandoned and the buffer dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP;
            ppc4_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ppc4_q     <= ppc4_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Outputs are straight register views so downstream stages see
    // glitch-free values for the whole cycle.
    always_comb begin
        imem_addr    = pc_q;
        if_valid     = valid_q;
        if_instr     = instr_q;
        if_pc_plus_4 = ppc4_q;
        addr_err     = addr_err_q;
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_sequencer
//
// Self-checking bench for fetch_pc_sequencer. A behavioural model tracks the
// architectural view (PC, one-entry buffer, whether decode refused the
// buffer last cycle) and a compare process checks every DUT output against
// it on each falling edge. Directed sequences add hand-computed literal
// expectations for the key scenarios.
// ----------------------------------------------------------------------------
module tb_fetch_pc_sequencer;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b1;
    logic [31:0] imemRdata;
    logic        ifValid;
    logic [31:0] ifInstr;
    logic [31:0] ifPcPlus4;
    logic        idReady = 1'b1;
    logic        exBranchTaken = 1'b0;
    logic [31:0] exBranchTarget = '0;
    logic        idJr = 1'b0;
    logic [31:0] idJrTarget = '0;
    logic        idJump = 1'b0;
    logic [25:0] idJumpIndex = '0;
    logic [31:0] idPcPlus4 = '0;
    logic        addrErr;

    int checks = 0;
    int errors = 0;
    bit compareOn = 1'b0;

    // Model state.
    logic        mRun = 1'b0;
    logic [31:0] mPc = RST_PC;
    logic        mValid = 1'b0;
    logic [31:0] mInstr = '0;
    logic [31:0] mPpc4 = '0;
    logic        mStalled = 1'b0;
    logic        mErr = 1'b0;

    fetch_pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imemReq),
        .imem_addr        (imemAddr),
        .imem_ready       (imemReady),
        .imem_rdata       (imemRdata),
        .if_valid         (ifValid),
        .if_instr         (ifInstr),
        .if_pc_plus_4     (ifPcPlus4),
        .id_ready         (idReady),
        .ex_branch_taken  (exBranchTaken),
        .ex_branch_target (exBranchTarget),
        .id_jr            (idJr),
        .id_jr_target     (idJrTarget),
        .id_jump          (idJump),
        .id_jump_index    (idJumpIndex),
        .id_pc_plus_4     (idPcPlus4),
        .addr_err         (addrErr)
    );

    // Memory returns a word derived from the address so every fetch is
    // distinguishable.
    assign imemRdata = imemAddr ^ MEM_KEY;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Fetch is offered when running, unless a buffered instruction is
    // waiting on decode (refused last cycle, or not being taken now).
    function automatic logic modelReq();
        return mRun && !(mValid && (mStalled || !idReady));
    endfunction

    function automatic logic [31:0] modelTarget();
        if (exBranchTaken) return exBranchTarget;
        if (idJr)          return idJrTarget;
        return {idPcPlus4[31:28], idJumpIndex, 2'b00};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mRun     <= 1'b0;
            mPc      <= RST_PC;
            mValid   <= 1'b0;
            mInstr   <= '0;
            mPpc4    <= '0;
            mStalled <= 1'b0;
            mErr     <= 1'b0;
        end else if (!mRun) begin
            mRun <= 1'b1;
            mErr <= 1'b0;
        end else if (exBranchTaken || idJr || idJump) begin
            mPc      <= modelTarget() & 32'hFFFF_FFFC;
            mValid   <= 1'b0;
            mStalled <= 1'b0;
            mErr     <= (modelTarget() % 4) != 0;
        end else begin
            mErr <= 1'b0;
            if (modelReq() && imemReady) begin
                mInstr   <= imemRdata;
                mPpc4    <= mPc + 32'd4;
                mPc      <= mPc + 32'd4;
                mValid   <= 1'b1;
                mStalled <= !idReady;
            end else begin
                mValid   <= mValid && !idReady;
                mStalled <= mValid && !idReady;
            end
        end
    end

    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("model imem_req",     {31'b0, imemReq}, {31'b0, modelReq()});
            checkOutput("model imem_addr",    imemAddr,         mPc);
            checkOutput("model if_valid",     {31'b0, ifValid}, {31'b0, mValid});
            checkOutput("model if_instr",     ifInstr,          mInstr);
            checkOutput("model if_pc_plus_4", ifPcPlus4,        mPpc4);
            checkOutput("model addr_err",     {31'b0, addrErr}, {31'b0, mErr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic br, input logic [31:0] bt,
                                 input logic jr, input logic [31:0] jt,
                                 input logic jmp, input logic [31:0] p4,
                                 input logic [25:0] idx);
        exBranchTaken  = br;
        exBranchTarget = bt;
        idJr           = jr;
        idJrTarget     = jt;
        idJump         = jmp;
        idPcPlus4      = p4;
        idJumpIndex    = idx;
    endtask

    task automatic clearRedirects();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        step();
        compareOn = 1'b1;
        step();
        #1;
        checkOutput("reset imem_req",     {31'b0, imemReq}, 32'd0);
        checkOutput("reset imem_addr",    imemAddr,         RST_PC);
        checkOutput("reset if_valid",     {31'b0, ifValid}, 32'd0);
        checkOutput("reset if_instr",     ifInstr,          32'd0);
        checkOutput("reset if_pc_plus_4", ifPcPlus4,        32'd0);
        checkOutput("reset addr_err",     {31'b0, addrErr}, 32'd0);

        // Reset release with memory and decode always ready.
        reset = 1'b0;
        step();
        #1;
        checkOutput("first req",  {31'b0, imemReq}, 32'd1);
        checkOutput("first addr", imemAddr,         32'h0040_0000);
        step();
        #1;
        checkOutput("second addr",      imemAddr,         32'h0040_0004);
        checkOutput("first valid",      {31'b0, ifValid}, 32'd1);
        checkOutput("first pc_plus_4",  ifPcPlus4,        32'h0040_0004);
        checkOutput("first instr",      ifInstr,          32'hA5E5_0000);
        step();
        #1;
        checkOutput("third addr",       imemAddr,  32'h0040_0008);
        checkOutput("second pc_plus_4", ifPcPlus4, 32'h0040_0008);

        // Decode stalls for three cycles.
        idReady = 1'b0;
        #1;
        checkOutput("stall req drop", {31'b0, imemReq}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            checkOutput("hold req",   {31'b0, imemReq}, 32'd0);
            checkOutput("hold addr",  imemAddr,         32'h0040_0008);
            checkOutput("hold instr", ifInstr,          32'hA5E5_0004);
            checkOutput("hold valid", {31'b0, ifValid}, 32'd1);
        end
        idReady = 1'b1;
        step();
        #1;
        checkOutput("resume req",   {31'b0, imemReq}, 32'd1);
        checkOutput("resume addr",  imemAddr,         32'h0040_0008);
        checkOutput("resume valid", {31'b0, ifValid}, 32'd0);
        step();

        // Branch and jump together: the branch wins.
        applyStimulus(1'b1, 32'h0000_2000, 1'b0, '0, 1'b1, 32'h9000_0010, 26'h0000100);
        step();
        clearRedirects();
        #1;
        checkOutput("branch wins addr", imemAddr,         32'h0000_2000);
        checkOutput("branch req",       {31'b0, imemReq}, 32'd1);
        checkOutput("branch flush",     {31'b0, ifValid}, 32'd0);
        step();
        #1;
        checkOutput("branch refill valid", {31'b0, ifValid}, 32'd1);

        // Jump alone.
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h9000_0010, 26'h0000100);
        step();
        clearRedirects();
        #1;
        checkOutput("jump addr", imemAddr, 32'h9000_0400);
        step();

        // Misaligned jr target.
        applyStimulus(1'b0, '0, 1'b1, 32'h0000_1006, 1'b0, '0, '0);
        step();
        clearRedirects();
        #1;
        checkOutput("jr aligned addr", imemAddr,         32'h0000_1004);
        checkOutput("jr addr_err",     {31'b0, addrErr}, 32'd1);
        step();
        #1;
        checkOutput("addr_err one cycle", {31'b0, addrErr}, 32'd0);
        checkOutput("jr next addr",       imemAddr,         32'h0000_1008);

        // PC wrap at the top of the address space.
        imemReady = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, '0);
        step();
        clearRedirects();
        #1;
        checkOutput("wrap start addr", imemAddr, 32'hFFFF_FFFC);
        imemReady = 1'b1;
        step();
        #1;
        checkOutput("wrap addr",      imemAddr,  32'h0000_0000);
        checkOutput("wrap pc_plus_4", ifPcPlus4, 32'h0000_0000);
        checkOutput("wrap instr",     ifInstr,   32'h5A5A_FFFC);

        // Redirect while parked in HOLD.
        idReady = 1'b0;
        step();
        #1;
        checkOutput("hold before jump", {31'b0, imemReq}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h1000_0000, 26'h0000040);
        step();
        clearRedirects();
        idReady = 1'b1;
        #1;
        checkOutput("hold jump addr",  imemAddr,         32'h1000_0100);
        checkOutput("hold jump req",   {31'b0, imemReq}, 32'd1);
        checkOutput("hold jump flush", {31'b0, ifValid}, 32'd0);

        // Mixed handshake and redirect patterns, checked by the model.
        for (int i = 0; i < 48; i++) begin
            idReady   = ((i % 5) != 2) && ((i % 7) != 3);
            imemReady = (i % 3) != 1;
            applyStimulus((i % 11) == 4, 32'h0000_3000 + 32'(i * 8),
                          (i % 13) == 9, 32'h0000_5001 + 32'(i),
                          (i % 17) == 6, 32'hC000_0000, 26'(i * 3));
            step();
        end
        clearRedirects();
        idReady   = 1'b1;
        imemReady = 1'b1;
        step();
        step();
        #1;
        checkOutput("stream req",   {31'b0, imemReq}, 32'd1);
        checkOutput("stream valid", {31'b0, ifValid}, 32'd1);

        // Reset mid-operation with a redirect held high.
        reset = 1'b1;
        applyStimulus(1'b1, 32'h0000_3000, 1'b0, '0, 1'b0, '0, '0);
        step();
        #1;
        checkOutput("midreset valid", {31'b0, ifValid}, 32'd0);
        checkOutput("midreset req",   {31'b0, imemReq}, 32'd0);
        checkOutput("midreset addr",  imemAddr,         RST_PC);
        step();
        #1;
        checkOutput("midreset addr hold", imemAddr,         RST_PC);
        checkOutput("midreset addr_err",  {31'b0, addrErr}, 32'd0);
        reset = 1'b0;
        step();
        #1;
        checkOutput("idle redirect ignored", imemAddr,         RST_PC);
        checkOutput("post reset req",        {31'b0, imemReq}, 32'd1);
        clearRedirects();
        step();
        step();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
